// File: rtl/calc_pkg.sv
// Shared helpers for the calculator front-end blocks.
package calc_pkg;

    // Register width for a counter that must represent values up to value-1,
    // never narrower than one bit so degenerate parameters still elaborate.
    function automatic int clog2_min1(input int value);
        int width;
        width = $clog2(value);
        return (width < 1) ? 1 : width;
    endfunction

endpackage

// File: rtl/debounce_tick.sv
// Sample-tick prescaler: one-cycle tick every TICK_DIV clocks.
// With TICK_DIV = 1 the counter is a single bit that stays at 0, so tick
// is permanently high.
module debounce_tick
    import calc_pkg::*;
#(
    parameter int TICK_DIV = 1024
) (
    input  logic clock,
    input  logic reset,
    output logic tick
);

    localparam int PW = clog2_min1(TICK_DIV);
    localparam logic [PW-1:0] LAST = PW'(TICK_DIV - 1);

    logic [PW-1:0] pcnt;

    assign tick = (pcnt == LAST);

    // Free-running phase counter, wrapping on the terminal count.
    always_ff @(posedge clock) begin
        // NOTE: state registers use non-blocking assignments so every flop
        // samples pre-edge values regardless of statement order.
        if (reset) begin
            pcnt <= '0;
        end else if (tick) begin
            pcnt <= '0;
        end else begin
            pcnt <= pcnt + PW'(1);
        end
    end

endmodule

// File: rtl/debouncer_multi.sv
// Multi-channel debouncer: per-channel two-flop synchroniser, optional
// polarity inversion and a symmetric counter filtering press and release.
// All channels share one prescaler, so the window is DB_COUNT sample ticks.
module debouncer_multi
    import calc_pkg::*;
#(
    parameter int N_CH       = 4,
    parameter int TICK_DIV   = 1024,
    parameter int DB_COUNT   = 10,
    parameter int ACTIVE_LOW = 0
) (
    input  logic            clock,
    input  logic            reset,
    input  logic [N_CH-1:0] signal,
    output logic [N_CH-1:0] db_signal,
    output logic [N_CH-1:0] rise,
    output logic [N_CH-1:0] fall
);

    localparam int CW = clog2_min1(DB_COUNT + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DB_COUNT - 1);
    // Raw level of an idle (inactive) input; also the synchroniser reset value.
    localparam logic RAW_IDLE = (ACTIVE_LOW != 0);

    logic tick;

    debounce_tick #(
        .TICK_DIV (TICK_DIV)
    ) u_tick (
        .clock (clock),
        .reset (reset),
        .tick  (tick)
    );

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        logic [1:0]    sync;
        logic          s;
        logic          db_q;
        logic          rise_q;
        logic          fall_q;
        logic [CW-1:0] cnt;

        // Two-flop synchroniser; resets to the idle raw level so that no
        // phantom edge is seen when reset releases.
        always_ff @(posedge clock) begin
            if (reset) begin
                sync <= {2{RAW_IDLE}};
            end else begin
                sync <= {sync[0], signal[i]};
            end
        end

        // Logical (1 = active) view of the synchronised input.
        assign s = sync[1] ^ RAW_IDLE;

        // Window counter and accepted level; any agreeing cycle restarts the
        // window, mismatching cycles only advance it on a sample tick.
        always_ff @(posedge clock) begin
            if (reset) begin
                db_q   <= 1'b0;
                cnt    <= '0;
                rise_q <= 1'b0;
                fall_q <= 1'b0;
            end else begin
                // NOTE: pulses default low each cycle and are only raised in
                // the acceptance branch, giving exactly one-cycle strobes.
                rise_q <= 1'b0;
                fall_q <= 1'b0;
                if (s == db_q) begin
                    cnt <= '0;
                end else if (tick) begin
                    if (cnt == CNT_LAST) begin
                        db_q   <= s;
                        cnt    <= '0;
                        rise_q <= s;
                        fall_q <= ~s;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
            end
        end

        assign db_signal[i] = db_q;
        assign rise[i]      = rise_q;
        assign fall[i]      = fall_q;
    end

endmodule

// File: tb/tb_debouncer_multi.sv
// Scoreboard bench for debouncer_multi: stimulus pushes expected edge events,
// monitors pop and compare whenever a rise/fall pulse appears.
module tb_debouncer_multi;

    localparam int TD = 4;
    localparam int DB = 3;

    typedef struct {
        int         cyc;
        logic [3:0] rise;
        logic [3:0] fall;
        logic [3:0] db;
    } ev_t;

    logic       clock;
    logic       reset;
    logic [3:0] signal;
    logic [3:0] db_signal, rise, fall;
    logic [3:0] signal_al;
    logic [3:0] db_signal_al, rise_al, fall_al;

    int   cyc;
    int   checks;
    int   errors;
    ev_t  q[$];
    ev_t  q_al[$];
    logic [3:0] lvl, lvl_al;
    logic [3:0] exp_db, exp_db_al;

    debouncer_multi #(
        .N_CH(4), .TICK_DIV(TD), .DB_COUNT(DB), .ACTIVE_LOW(0)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .signal    (signal),
        .db_signal (db_signal),
        .rise      (rise),
        .fall      (fall)
    );

    debouncer_multi #(
        .N_CH(4), .TICK_DIV(1), .DB_COUNT(DB), .ACTIVE_LOW(1)
    ) dut_al (
        .clock     (clock),
        .reset     (reset),
        .signal    (signal_al),
        .db_signal (db_signal_al),
        .rise      (rise_al),
        .fall      (fall_al)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Bench cycle counter: 0 on the edge that samples reset.
    always @(posedge clock) begin
        if (reset) cyc <= 0;
        else       cyc <= cyc + 1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h (cyc %0d)", name, act, req, cyc);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    // Edge at which a clean raw edge driven after cycle a is accepted:
    // the synchronised value is first seen at edge a+3, then DB ticks
    // (edges at multiples of TD) are needed.
    function automatic int accept_at(input int a);
        int k;
        k = a + 3;
        while (k % TD != 0) k++;
        return k + (DB - 1) * TD;
    endfunction

    task automatic expect_change(input int at, input logic [3:0] nl);
        ev_t e;
        e.cyc  = at;
        e.rise = nl & ~lvl;
        e.fall = lvl & ~nl;
        e.db   = nl;
        q.push_back(e);
        lvl = nl;
    endtask

    task automatic expect_change_al(input int at, input logic [3:0] nl);
        ev_t e;
        e.cyc  = at;
        e.rise = nl & ~lvl_al;
        e.fall = lvl_al & ~nl;
        e.db   = nl;
        q_al.push_back(e);
        lvl_al = nl;
    endtask

    // Monitor for the main DUT.
    always @(negedge clock) begin
        ev_t e;
        if (reset) begin
            exp_db = '0;
        end else begin
            if ((rise | fall) != 4'b0) begin
                if (q.size() == 0) begin
                    check("unexpected_pulse", {24'b0, rise, fall}, 32'b0);
                end else begin
                    e = q.pop_front();
                    check("edge_cycle", cyc, e.cyc);
                    check("rise", {28'b0, rise}, {28'b0, e.rise});
                    check("fall", {28'b0, fall}, {28'b0, e.fall});
                    exp_db = e.db;
                end
            end
            check("db_level", {28'b0, db_signal}, {28'b0, exp_db});
        end
    end

    // Monitor for the active-low, tick-every-cycle DUT.
    always @(negedge clock) begin
        ev_t e;
        if (reset) begin
            exp_db_al = '0;
        end else begin
            if ((rise_al | fall_al) != 4'b0) begin
                if (q_al.size() == 0) begin
                    check("al_unexpected_pulse", {24'b0, rise_al, fall_al}, 32'b0);
                end else begin
                    e = q_al.pop_front();
                    check("al_edge_cycle", cyc, e.cyc);
                    check("al_rise", {28'b0, rise_al}, {28'b0, e.rise});
                    check("al_fall", {28'b0, fall_al}, {28'b0, e.fall});
                    exp_db_al = e.db;
                end
            end
            check("al_db_level", {28'b0, db_signal_al}, {28'b0, exp_db_al});
        end
    end

    initial begin
        checks    = 0;
        errors    = 0;
        lvl       = '0;
        lvl_al    = '0;
        exp_db    = '0;
        exp_db_al = '0;
        signal    = 4'b0000;
        signal_al = 4'b1111;
        reset     = 1'b1;
        step(3);
        reset = 1'b0;

        // Reset state.
        check("rst_db", {28'b0, db_signal}, 32'h0);
        check("rst_rise", {28'b0, rise}, 32'h0);
        check("rst_fall", {28'b0, fall}, 32'h0);
        check("rst_al_db", {28'b0, db_signal_al}, 32'h0);
        check("rst_al_rise", {28'b0, rise_al}, 32'h0);
        check("rst_al_fall", {28'b0, fall_al}, 32'h0);

        // Clean press on channel 0.
        step(2);
        signal[0] = 1'b1;
        expect_change(accept_at(cyc), 4'b0001);
        step(20);

        // Bounce on channel 1: 3-cycle toggles never span a window.
        for (int i = 0; i < 20; i++) begin
            signal[1] = ~signal[1];
            step(3);
        end
        signal[1] = 1'b1;
        expect_change(accept_at(cyc), 4'b0011);
        step(20);

        // Channel 2 press, then release with a 1-cycle glitch at cycle 6.
        signal[2] = 1'b1;
        expect_change(accept_at(cyc), 4'b0111);
        step(20);
        signal[2] = 1'b0;
        step(6);
        signal[2] = 1'b1;
        step(1);
        signal[2] = 1'b0;
        expect_change(accept_at(cyc), 4'b0011);
        step(25);

        // Release two channels together, then press all four together.
        signal[1:0] = 2'b00;
        expect_change(accept_at(cyc), 4'b0000);
        step(20);
        signal = 4'b1111;
        expect_change(accept_at(cyc), 4'b1111);
        step(20);
        signal = 4'b0000;
        expect_change(accept_at(cyc), 4'b0000);
        step(20);

        // Reset mid-count: the window restarts from reset release.
        signal[0] = 1'b1;
        step(8);
        reset = 1'b1;
        step(1);
        reset = 1'b0;
        expect_change(accept_at(cyc), 4'b0001);
        step(20);

        // Active-low instance, tick every cycle: exactly 5 cycles.
        signal_al[3] = 1'b0;
        expect_change_al(cyc + 5, 4'b1000);
        step(10);
        signal_al[2] = 1'b0;          // 1-cycle low pulse: rejected
        step(1);
        signal_al[2] = 1'b1;
        step(10);
        signal_al[1] = 1'b0;          // 2-cycle low pulse: rejected
        step(2);
        signal_al[1] = 1'b1;
        step(10);
        signal_al[3] = 1'b1;
        expect_change_al(cyc + 5, 4'b0000);
        step(10);

        // Drain with a bounded wait.
        for (int i = 0; i < 200 && (q.size() != 0 || q_al.size() != 0); i++) begin
            @(posedge clock);
        end
        step(1);
        check("queue_drained", q.size(), 32'd0);
        check("al_queue_drained", q_al.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/debouncer_multi.md
# debouncer_multi

Parametrised multi-channel debouncer for raw button/switch inputs feeding the calculator keypad and control logic. Each channel gets a two-flop synchroniser, optional polarity inversion, and a symmetric counter that filters both press and release. Outputs are a clean level plus one-cycle rise/fall pulses. All channels share one sample-tick prescaler, so the filter window is set in clock cycles.

## Interface
- `N_CH`, 4: number of independent input channels (≥1)
- `TICK_DIV`, 1024: clock cycles per sample tick (≥1; 1 = tick every cycle)
- `DB_COUNT`, 10: consecutive mismatching ticks required to accept a new level (≥1)
- `ACTIVE_LOW`, 0: 1 = raw input is active-low; inverted after synchronisation
- `clock` in 1: system clock; the only clock
- `reset` in 1: synchronous, active-high reset
- `signal` in N_CH: raw asynchronous inputs
- `db_signal` out N_CH: debounced level, logical (1 = active)
- `rise` out N_CH: one-cycle pulse when db_signal goes 0→1
- `fall` out N_CH: one-cycle pulse when db_signal goes 1→0

## Operation
- Synchroniser: two flops per channel on `signal`. Reset value is the raw inactive level: 0, or 1 if ACTIVE_LOW. `s[i]` is the synchronised output XOR ACTIVE_LOW.
- Prescaler: counter `pcnt`, width max(1,$clog2(TICK_DIV)). `tick` = (pcnt == TICK_DIV-1). pcnt wraps to 0 on tick and otherwise increments. For TICK_DIV=1, tick is constantly 1.
- Per-channel counter `cnt[i]`, width $clog2(DB_COUNT+1), evaluated every clock:
  - s[i] == db_signal[i]: cnt ← 0. This is checked on every cycle, not only on ticks, so any agreeing cycle restarts the window.
  - s[i] != db_signal[i] and tick and cnt == DB_COUNT-1: db_signal[i] ← s[i], cnt ← 0, and the matching rise/fall pulse asserts.
  - s[i] != db_signal[i] and tick otherwise: cnt ← cnt+1.
  - s[i] != db_signal[i] and no tick: hold.
- Press and release filtering are symmetric.
- Channels are fully independent. Several channels may change in the same cycle.
- rise[i]/fall[i] are registered and high for exactly the cycle in which db_signal[i] first shows the new value. They are never both high.
- Reset values: db_signal = 0, rise = 0, fall = 0, all cnt = 0, pcnt = 0. Reset mid-count discards the count. After reset, an input that is already active must be re-qualified for the full window, then produces a rise pulse.

## Timing
- Synchroniser latency: 2 clocks.
- Acceptance latency from a clean raw edge to the db_signal change lies in [3+(DB_COUNT-1)·TICK_DIV, 2+DB_COUNT·TICK_DIV] clocks, depending on prescaler phase.
- First tick after reset release occurs TICK_DIV cycles later.
- A glitch that agrees with the current db_signal for ≥1 synchronised cycle restarts the window.
- Input toggling faster than the window never changes the output.
- No throughput limit: the next transition may begin qualifying the cycle after acceptance.

## Structure
- Shared package `calc_pkg`: function for counter width (clog2 with minimum 1). No typedefs are required.
- Sub-module `debounce_tick`, parameter TICK_DIV, ports clock/reset/tick. This is the prescaler, shared across channels and reusable by other timed blocks.
- Per-channel logic is a generate loop inside `debouncer_multi`. No per-channel sub-module.

## Test plan
Config for all scenarios: N_CH=4, TICK_DIV=4, DB_COUNT=3, ACTIVE_LOW=0, unless noted.
- Clean press: signal[0] 0→1 held. db_signal[0] rises 11–14 cycles later. rise[0] is high for exactly 1 cycle, coincident with the change. Other channels stay 0.
- Bounce rejection: signal[1] toggled every 3 cycles for 60 cycles. db_signal[1] stays 0, no pulses. Then held at 1: accepted within 14 cycles, single rise.
- Release: starting from db_signal[2]=1, drop signal[2] to 0. fall[2] pulses once after 11–14 cycles. A 1-cycle high glitch at cycle 6 restarts the window, so the change occurs ≥12 cycles after the glitch.
- Simultaneous channels: all four inputs rise in the same cycle. All db_signal bits and rise bits assert in the same cycle.
- Reset mid-count: signal[0]=1, reset pulsed for 1 cycle after 8 cycles. db_signal stays 0 until a full new window (11–14 cycles after reset release), then rise[0] pulses.
- ACTIVE_LOW=1, TICK_DIV=1: signal idle 1 gives db_signal=0. Drive signal[3]=0 and db_signal[3] goes to 1 after exactly 5 cycles.
